drv_burst_sequencer: RTL and testbench

//  Sequences the DRV2 drive output from the SYN1OUT sync input in the CLK_5M domain.

---
 rtl/drv_burst_sequencer.sv | 129 ++++++++++++
 tb/tb_drv_burst_sequencer.sv | 123 ++++++++++++
 2 files changed

// File: rtl/drv_burst_sequencer.sv
// drv_burst_sequencer: SYN1OUT-triggered delay + N-pulse burst on DRV2; SYNC_WATCHDOG_EN adds the sync_lost watchdog
module drv_burst_sequencer #(
  parameter int CNT_W       = 16,
  parameter int NP_W        = 8,
  parameter int SYNC_STAGES = 2,
  parameter int WDOG_CYC    = 50000
) (
  input  logic             CLKIN,
  input  logic             Reset,
  input  logic             SYN1OUT,
  input  logic             enable,
  input  logic [CNT_W-1:0] cfg_delay,
  input  logic [CNT_W-1:0] cfg_high,
  input  logic [CNT_W-1:0] cfg_low,
  input  logic [NP_W-1:0]  cfg_npulse,
  output logic             DRV2,
  output logic             busy,
  output logic             done,
  output logic             overrun,
  output logic             sync_lost
);
  typedef enum logic [2:0] {IDLE, DELAY, HIGH, LOW, DONE} state_t;
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx, l_high, l_low, high_eff, low_eff;
  logic [NP_W-1:0] pcnt, pcnt_nx, l_np;
  logic [SYNC_STAGES-1:0] sync;
  logic sync_prev, trig, start, ph_end;
  assign high_eff = (cfg_high == '0) ? CNT_W'(1) : cfg_high;
  assign low_eff  = (cfg_low == '0) ? CNT_W'(1) : cfg_low;
  assign start    = trig & enable & (cfg_npulse != '0) & (state == IDLE);
  assign ph_end   = cnt == CNT_W'(1);
  // SYN1OUT synchronizer and registered rising-edge detect
  always_ff @(posedge CLKIN or negedge Reset)
    if (!Reset) begin
      sync      <= '0;
      sync_prev <= 1'b0;
      trig      <= 1'b0;
    end else begin
      sync      <= {sync[SYNC_STAGES-2:0], SYN1OUT};
      sync_prev <= sync[SYNC_STAGES-1];
      trig      <= sync[SYNC_STAGES-1] & ~sync_prev;
    end
  // state, counters, latched config and the DRV2 output flop
  always_ff @(posedge CLKIN or negedge Reset)
    if (!Reset) begin
      state  <= IDLE;
      cnt    <= '0;
      pcnt   <= '0;
      l_high <= '0;
      l_low  <= '0;
      l_np   <= '0;
      DRV2   <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      pcnt  <= pcnt_nx;
      DRV2  <= state_nx == HIGH;
      if (start) begin
        l_high <= high_eff;
        l_low  <= low_eff;
        l_np   <= cfg_npulse;
      end
    end
  // next state: phase counter loads a length and counts down to 1
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    pcnt_nx  = pcnt;
    if (state != IDLE && !enable) begin
      state_nx = IDLE;
      cnt_nx   = '0;
      pcnt_nx  = '0;
    end else
      case (state)
        IDLE: if (start) begin
          state_nx = (cfg_delay != '0) ? DELAY : HIGH;
          cnt_nx   = (cfg_delay != '0) ? cfg_delay : high_eff;
          pcnt_nx  = '0;
        end
        DELAY: begin
          state_nx = ph_end ? HIGH : DELAY;
          cnt_nx   = ph_end ? l_high : cnt - CNT_W'(1);
        end
        HIGH: begin
          state_nx = ph_end ? LOW : HIGH;
          cnt_nx   = ph_end ? l_low : cnt - CNT_W'(1);
          pcnt_nx  = ph_end ? pcnt + NP_W'(1) : pcnt;
        end
        LOW: begin
          state_nx = !ph_end ? LOW : (pcnt < l_np) ? HIGH : DONE;
          cnt_nx   = !ph_end ? cnt - CNT_W'(1) : (pcnt < l_np) ? l_high : '0;
        end
        DONE: begin
          state_nx = IDLE;
          cnt_nx   = '0;
          pcnt_nx  = '0;
        end
        default: begin
          state_nx = IDLE;
          cnt_nx   = '0;
          pcnt_nx  = '0;
        end
      endcase
  end
  // status outputs decoded from registered state and trigger
  always_comb begin
    busy    = state != IDLE;
    done    = state == DONE;
    overrun = trig & (state != IDLE);
  end
`ifdef SYNC_WATCHDOG_EN
  localparam int WD_W = $clog2(WDOG_CYC + 1);
  logic [WD_W-1:0] wd;
  // watchdog: counts enabled cycles since the last trigger, sticky flag at WDOG_CYC
  always_ff @(posedge CLKIN or negedge Reset)
    if (!Reset) begin
      wd        <= '0;
      sync_lost <= 1'b0;
    end else if (!enable || trig) begin
      wd        <= '0;
      sync_lost <= 1'b0;
    end else begin
      wd        <= (wd == WD_W'(WDOG_CYC)) ? wd : wd + WD_W'(1);
      sync_lost <= sync_lost | (wd == WD_W'(WDOG_CYC - 1));
    end
`else
  assign sync_lost = 1'b0;
`endif
endmodule

// File: tb/tb_drv_burst_sequencer.sv
// tb_drv_burst_sequencer: directed burst traces against hand-computed cycle masks
module tb_drv_burst_sequencer;
  logic CLKIN = 1'b0;
  logic Reset = 1'b0;
  logic SYN1OUT = 1'b0;
  logic enable = 1'b1;
  logic [15:0] cfg_delay = '0, cfg_high = '0, cfg_low = '0;
  logic [7:0] cfg_npulse = '0;
  logic DRV2, busy, done, overrun, sync_lost;
  logic [63:0] drv_t, busy_t, done_t, ovr_t;
  int n_vec = 0;
  int n_err = 0;

  drv_burst_sequencer #(.CNT_W(16), .NP_W(8), .SYNC_STAGES(2), .WDOG_CYC(100)) dut (
    .CLKIN(CLKIN), .Reset(Reset), .SYN1OUT(SYN1OUT), .enable(enable),
    .cfg_delay(cfg_delay), .cfg_high(cfg_high), .cfg_low(cfg_low), .cfg_npulse(cfg_npulse),
    .DRV2(DRV2), .busy(busy), .done(done), .overrun(overrun), .sync_lost(sync_lost)
  );

  always #5 CLKIN = ~CLKIN;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_cfg(input int d, input int h, input int l, input int n);
    cfg_delay = 16'(d);
    cfg_high = 16'(h);
    cfg_low = 16'(l);
    cfg_npulse = 8'(n);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLKIN);
  endtask

  // pin edge just before posedge 1; bit i of each trace is the value seen in cycle i (trig lands in cycle 3)
  task automatic capture(input int ncyc, input int edge2, input int drop, input int rst_at, input int chg);
    drv_t = '0; busy_t = '0; done_t = '0; ovr_t = '0;
    SYN1OUT = 1'b1;
    for (int i = 1; i <= ncyc; i++) begin
      @(posedge CLKIN);
      @(negedge CLKIN);
      drv_t[i] = DRV2; busy_t[i] = busy; done_t[i] = done; ovr_t[i] = overrun;
      if (i == 2) SYN1OUT = 1'b0;
      if (i == edge2) SYN1OUT = 1'b1;
      if (i == edge2 + 1) SYN1OUT = 1'b0;
      if (i == drop) enable = 1'b0;
      if (i == chg) set_cfg(1, 9, 9, 5);
      if (i == rst_at) begin
        #2 Reset = 1'b0;
        #1 check("rst_async", {60'd0, DRV2, busy, done, overrun}, 64'd0);
      end
      if (i == rst_at + 2) Reset = 1'b1;
    end
    SYN1OUT = 1'b0;
    enable = 1'b1;
    idle(6);
  endtask

  task automatic check_traces(input string tag, input logic [63:0] d, input logic [63:0] b,
                              input logic [63:0] dn, input logic [63:0] o);
    check({tag, "_drv"}, drv_t, d);
    check({tag, "_busy"}, busy_t, b);
    check({tag, "_done"}, done_t, dn);
    check({tag, "_ovr"}, ovr_t, o);
  endtask

  initial begin
    logic exp_lost;
    idle(3);
    check("reset_out", {59'd0, DRV2, busy, done, overrun, sync_lost}, 64'd0);
    Reset = 1'b1;
    idle(3);
    set_cfg(3, 2, 4, 2);
    capture(24, -1, -1, -1, -1);
    check_traces("basic", 64'h6180, 64'hFFFF0, 64'h80000, 64'h0);
    set_cfg(0, 0, 0, 1);
    capture(12, -1, -1, -1, -1);
    check_traces("zero", 64'h10, 64'h70, 64'h40, 64'h0);
    set_cfg(3, 2, 4, 0);
    capture(12, -1, -1, -1, -1);
    check_traces("np0", 64'h0, 64'h0, 64'h0, 64'h0);
    set_cfg(3, 2, 4, 2);
    capture(24, 6, -1, -1, -1);
    check_traces("ovr_low", 64'h6180, 64'hFFFF0, 64'h80000, 64'h200);
    set_cfg(3, 2, 4, 2);
    capture(30, 16, -1, -1, 5);
    check_traces("ovr_done", 64'h6180, 64'hFFFF0, 64'h80000, 64'h80000);
    set_cfg(3, 2, 4, 2);
    capture(24, -1, 13, -1, -1);
    check_traces("abort", 64'h2180, 64'h3FF0, 64'h0, 64'h0);
    set_cfg(3, 2, 4, 2);
    capture(20, -1, -1, 8, -1);
    check_traces("reset_mid", 64'h180, 64'h1F0, 64'h0, 64'h0);
    enable = 1'b0;
    capture(14, 6, -1, -1, -1);
    check_traces("en0_idle", 64'h0, 64'h0, 64'h0, 64'h0);
`ifdef SYNC_WATCHDOG_EN
    exp_lost = 1'b1;
`else
    exp_lost = 1'b0;
`endif
    enable = 1'b0;
    idle(1);
    enable = 1'b1;
    idle(99);
    check("wdog_99", {63'd0, sync_lost}, 64'd0);
    idle(1);
    check("wdog_100", {63'd0, sync_lost}, {63'd0, exp_lost});
    SYN1OUT = 1'b1;
    idle(4);
    check("wdog_clr", {63'd0, sync_lost}, 64'd0);
    SYN1OUT = 1'b0;
    idle(4);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
